// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: reset level, flags,
// bus types and the fetch address increment.
package inst_fetch_queue_pkg;

  localparam logic RstEnableN = 1'b0;
  localparam logic True       = 1'b1;
  localparam logic False      = 1'b0;

  typedef logic [31:0] inst_bus_t;
  typedef logic [31:0] inst_addr_bus_t;

  localparam inst_addr_bus_t WordInc = 32'd4;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous (inst, pc) FIFO with flush; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module inst_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  inst_bus_t                    data_in,
  input  inst_addr_bus_t               pc_in,
  output inst_bus_t                    data_out,
  output inst_addr_bus_t               pc_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  inst_bus_t      data_mem [DEPTH];
  inst_addr_bus_t pc_mem   [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic           do_push;
  logic           do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = data_mem[head];
  assign pc_out   = pc_mem[head];

  always_ff @(posedge clk) begin
    if (rst == RstEnableN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        data_mem[tail] <= data_in;
        pc_mem[tail]   <= pc_in;
        tail           <= tail + 1'b1;
      end
      if (do_pop) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch stage: drives the next fetch address, accepts in-order words by
// address compare, and queues them for decode; redirect flushes and refetches.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned    DEPTH    = 4,
  parameter inst_addr_bus_t RESET_PC = 32'h0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_take,
  input  logic           mem_avalible,
  input  inst_bus_t      mem_inst,
  input  inst_addr_bus_t mem_inst_addr,
  output inst_addr_bus_t mem_fetch_addr,
  input  logic           redirect,
  input  inst_addr_bus_t redirect_pc,
  output logic           id_valid,
  output inst_bus_t      id_inst,
  output inst_addr_bus_t id_pc,
  input  logic           id_ready
);

  inst_addr_bus_t               expect_pc;
  logic                         pop;
  logic                         accept;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count;
  logic                         unused_sink;

  // The controller always fetches expect_pc next, so the take strobe carries
  // no information this stage needs.
  assign unused_sink = &{1'b0, mem_take, fifo_count};

  assign mem_fetch_addr = redirect ? redirect_pc : expect_pc;
  assign id_valid       = !fifo_empty;
  assign pop            = id_valid && id_ready && !redirect;
  assign accept         = mem_avalible && !redirect &&
                          (mem_inst_addr == expect_pc) && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst == RstEnableN) begin
      expect_pc <= RESET_PC;
    end else if (redirect) begin
      expect_pc <= redirect_pc;
    end else if (accept) begin
      expect_pc <= expect_pc + WordInc;
    end
  end

  inst_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept),
    .pop      (pop),
    .flush    (redirect),
    .data_in  (mem_inst),
    .pc_in    (mem_inst_addr),
    .data_out (id_inst),
    .pc_out   (id_pc),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed controller words, expected
// decode handoffs queued by stimulus and checked by a negedge monitor.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_take;
  logic        mem_avalible;
  logic [31:0] mem_inst;
  logic [31:0] mem_inst_addr;
  logic [31:0] mem_fetch_addr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_ready;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_take       (mem_take),
    .mem_avalible   (mem_avalible),
    .mem_inst       (mem_inst),
    .mem_inst_addr  (mem_inst_addr),
    .mem_fetch_addr (mem_fetch_addr),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .id_ready       (id_ready)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every decode handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && !redirect && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop actual_pc=%h required=none", id_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", id_pc, e[31:0]);
        chk("pop_inst", id_inst, e[63:32]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One controller word; caller states whether it must be accepted and
  // what the fetch address must be beforehand.
  task automatic word(input logic [31:0] a, input bit acc, input logic [31:0] f, input bit vis);
    #1;
    chk("fetch_addr", mem_fetch_addr, f);
    mem_take      = 1'b1;
    mem_avalible  = 1'b1;
    mem_inst_addr = a;
    mem_inst      = inst_of(a);
    if (acc) exp_q.push_back({inst_of(a), a});
    @(posedge clk);
    #1;
    mem_take     = 1'b0;
    mem_avalible = 1'b0;
    if (vis) begin
      @(negedge clk);
      chk("vis_valid", {31'b0, id_valid}, 32'd1);
      chk("vis_pc", id_pc, a);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    #1;
    chk("redir_fetch", mem_fetch_addr, pc);
    exp_q.delete();
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("redir_valid", {31'b0, id_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; mem_take = 1'b0; mem_avalible = 1'b0; mem_inst = '0;
    mem_inst_addr = '0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_fetch", mem_fetch_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // In-order delivery, each visible the cycle after arrival
    id_ready = 1'b1;
    word(32'h0, 1, 32'h0, 1); idle(2);
    word(32'h4, 1, 32'h4, 1); idle(2);
    word(32'h8, 1, 32'h8, 1); idle(2);

    // Fill with decode stalled, overflow dropped, one pop, refetch
    id_ready = 1'b0;
    word(32'hC,  1, 32'hC,  0);
    word(32'h10, 1, 32'h10, 0);
    word(32'h14, 1, 32'h14, 0);
    word(32'h18, 1, 32'h18, 0);
    word(32'h1C, 0, 32'h1C, 0);
    idle(1);
    #1 chk("full_fetch_hold", mem_fetch_addr, 32'h1C);
    id_ready = 1'b1;
    idle(1);
    id_ready = 1'b0;
    word(32'h1C, 1, 32'h1C, 0);

    // Full with simultaneous pop and matching word
    id_ready = 1'b1;
    word(32'h20, 1, 32'h20, 0);
    id_ready = 1'b0;
    word(32'h24, 0, 32'h24, 0);
    id_ready = 1'b1;
    idle(6);
    chk("drain1_empty", exp_q.size(), 32'd0);

    // Redirect with three queued words
    id_ready = 1'b0;
    word(32'h24, 1, 32'h24, 0);
    word(32'h28, 1, 32'h28, 0);
    word(32'h2C, 1, 32'h2C, 0);
    do_redirect(32'h100);
    id_ready = 1'b1;
    word(32'h100, 1, 32'h100, 1);

    // Stale in-flight word after redirect
    do_redirect(32'h200);
    word(32'h104, 0, 32'h200, 0);
    @(negedge clk);
    chk("stale_valid", {31'b0, id_valid}, 32'd0);
    @(posedge clk); #1;
    word(32'h200, 1, 32'h200, 1);

    // Accept and pop together at count 1
    id_ready = 1'b0;
    word(32'h204, 1, 32'h204, 0);
    id_ready = 1'b1;
    word(32'h208, 1, 32'h208, 1);

    // Reset mid-stream with three queued words
    id_ready = 1'b0;
    word(32'h20C, 1, 32'h20C, 0);
    word(32'h210, 1, 32'h210, 0);
    word(32'h214, 1, 32'h214, 0);
    rst = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_valid", {31'b0, id_valid}, 32'd0);
    chk("mrst_fetch", mem_fetch_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    word(32'h218, 0, 32'h0, 0);
    @(negedge clk);
    chk("mrst_stale_valid", {31'b0, id_valid}, 32'd0);
    @(posedge clk); #1;
    id_ready = 1'b1;
    word(32'h0, 1, 32'h0, 1);
    idle(4);
    chk("final_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
